// File: rtl/shift_sequencer_if.sv
// Bundle between the board switch/button logic and the shift sequencer.
// The master side issues commands and operands. The slave side (the sequencer)
// returns the latched operand, direction and stepping shift amount.
interface shift_sequencer_if #(
  parameter int WIDTH = 6,
  parameter int SHW   = 3
);

  logic             start;
  logic             abort;
  logic             dir_in;
  logic [WIDTH-1:0] x_in;
  logic [SHW-1:0]   shamt_in;

  logic             dir_out;
  logic [WIDTH-1:0] x_out;
  logic [SHW-1:0]   shamt_out;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, dir_in, x_in, shamt_in,
    input  dir_out, x_out, shamt_out, busy, done
  );

  modport slave (
    input  start, abort, dir_in, x_in, shamt_in,
    output dir_out, x_out, shamt_out, busy, done
  );

endinterface

// File: rtl/shift_sequencer.sv
// Animates the shift unit. One accepted start latches the operand, the direction
// and the target amount. The shift amount then steps from 0 up to the target,
// advancing once every TICK_DIV cycles. After the run, the display values stay
// as they were until the next start or reset.
module shift_sequencer #(
  parameter int WIDTH    = 6,
  parameter int SHW      = 3,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   tick_cnt;
  logic [SHW-1:0]  target;
  logic [SHW-1:0]  shamt_next;

  // The amount never exceeds target (at most 2^SHW-1), so this add cannot wrap in use.
  assign shamt_next = bus.shamt_out + 1'b1;

  // Sequencer FSM with registered outputs: accept, step on prescaled ticks, pulse done.
  always_ff @(posedge clk) begin
    // NOTE: all state here updates with <= so every branch sees the pre-edge values.
    if (rst) begin
      // NOTE: target is reset as well. A run is only entered through IDLE, which
      // reloads it, but a known value keeps the idle register contents deterministic.
      state         <= IDLE;
      tick_cnt      <= '0;
      target        <= '0;
      bus.dir_out   <= 1'b0;
      bus.x_out     <= '0;
      bus.shamt_out <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Abort has priority over start, so a simultaneous request is dropped.
          if (bus.start && !bus.abort) begin
            bus.x_out     <= bus.x_in;
            bus.dir_out   <= bus.dir_in;
            target        <= bus.shamt_in;
            bus.shamt_out <= '0;
            tick_cnt      <= '0;
            bus.busy      <= 1'b1;
            if (bus.shamt_in == '0) begin
              state    <= FINISH;
              bus.done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (bus.abort) begin
            // The operand and the partial amount are held for display; no done pulse.
            state    <= IDLE;
            tick_cnt <= '0;
            bus.busy <= 1'b0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt      <= '0;
            bus.shamt_out <= shamt_next;
            if (shamt_next == target) begin
              state    <= FINISH;
              bus.done <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        FINISH: begin
          // This state lasts one cycle and ignores abort, so the done pulse always completes.
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer with TICK_DIV=4. Directed scenarios are followed
// by random traffic. Every cycle is compared against a run-level model. That model
// records the accept edge n and the finish edge f = n + target*TICK_DIV. It
// derives the current amount arithmetically as (t-n)/TICK_DIV.
module tb_shift_sequencer;

  localparam int WIDTH = 6;
  localparam int SHW   = 3;
  localparam int TD    = 4;

  logic clk;
  logic rst;

  shift_sequencer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int t           = 0;

  // Reference model state.
  bit               m_active = 1'b0;
  int               m_n      = 0;
  int               m_f      = 0;
  logic [WIDTH-1:0] m_x      = '0;
  logic             m_dir    = 1'b0;
  logic [SHW-1:0]   m_shamt  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Applies the inputs sampled at edge t to the model.
  function automatic void model_update();
    if (rst) begin
      m_active = 1'b0;
      m_x      = '0;
      m_dir    = 1'b0;
      m_shamt  = '0;
    end else if (m_active) begin
      if (t - 1 == m_f)       m_active = 1'b0;   // the finish cycle has ended
      else if (bus.abort)     m_active = 1'b0;   // abort during a run; values hold
      else                    m_shamt  = SHW'((t - m_n) / TD);
    end else if (bus.start && !bus.abort) begin
      m_active = 1'b1;
      m_n      = t;
      m_f      = t + int'(bus.shamt_in) * TD;
      m_x      = bus.x_in;
      m_dir    = bus.dir_in;
      m_shamt  = '0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    t++;
    model_update();
    #1;
    check("x_out",     bus.x_out,     m_x);
    check("dir_out",   bus.dir_out,   m_dir);
    check("shamt_out", bus.shamt_out, m_shamt);
    check("busy",      bus.busy,      m_active);
    check("done",      bus.done,      m_active && (t == m_f));
  endtask

  task automatic drive(input logic s, input logic a, input logic d,
                       input logic [WIDTH-1:0] x, input logic [SHW-1:0] sh);
    bus.start    = s;
    bus.abort    = a;
    bus.dir_in   = d;
    bus.x_in     = x;
    bus.shamt_in = sh;
  endtask

  task automatic run_case1();
    drive(1'b1, 1'b0, 1'b1, 6'b000111, 3'd3);
    tick();
    bus.start = 1'b0;
    check("c1_busy_after_accept", bus.busy, 1);
    repeat (4) tick();
    check("c1_step1", bus.shamt_out, 1);
    repeat (4) tick();
    check("c1_step2", bus.shamt_out, 2);
    repeat (4) tick();
    check("c1_step3", bus.shamt_out, 3);
    check("c1_done", bus.done, 1);
    tick();
    check("c1_done_low", bus.done, 0);
    check("c1_idle", bus.busy, 0);
    check("c1_hold", bus.shamt_out, 3);
    check("c1_x_hold", bus.x_out, 6'b000111);
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    check("rst_shamt", bus.shamt_out, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    // Case 1: basic three-step run.
    run_case1();

    // Case 2: zero target goes straight to the done pulse.
    drive(1'b1, 1'b0, 1'b1, 6'b101010, 3'd0);
    tick();
    bus.start = 1'b0;
    check("c2_done", bus.done, 1);
    check("c2_shamt", bus.shamt_out, 0);
    tick();
    check("c2_idle", bus.busy, 0);
    tick();

    // Case 3: maximum target, no wrap.
    drive(1'b1, 1'b0, 1'b0, 6'b111111, 3'd7);
    tick();
    bus.start = 1'b0;
    repeat (28) tick();
    check("c3_shamt7", bus.shamt_out, 7);
    check("c3_done", bus.done, 1);
    repeat (3) tick();
    check("c3_no_wrap", bus.shamt_out, 7);

    // Case 4: abort in cycle 10 of a five-step run.
    drive(1'b1, 1'b0, 1'b1, 6'b010101, 3'd5);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("c4_idle", bus.busy, 0);
    check("c4_shamt_held", bus.shamt_out, 2);
    repeat (25) tick();

    // Case 5: start held, operands changing mid-run.
    drive(1'b1, 1'b0, 1'b1, 6'b110011, 3'd2);
    for (int i = 0; i < 40; i++) begin
      tick();
      bus.x_in   = WIDTH'($urandom);
      bus.dir_in = 1'($urandom);
    end
    bus.start = 1'b0;
    repeat (10) tick();

    // Case 6: reset in cycle 7 of a run, then a clean run.
    drive(1'b1, 1'b0, 1'b1, 6'b001100, 3'd4);
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("c6_rst_shamt", bus.shamt_out, 0);
    check("c6_rst_x", bus.x_out, 0);
    check("c6_rst_busy", bus.busy, 0);
    tick();
    run_case1();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
            1'($urandom), WIDTH'($urandom), SHW'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
